// File: rtl/sys_csr_bridge.sv
// sys_csr_bridge: single-outstanding valid/ready CSR slave driving sys_config and observing sys_status.
// Define SYS_CSR_IRQ_EN to implement IRQ_MASK (0x10) and a registered irq_o; otherwise irq_o is tied low.
module sys_csr_bridge #(
    parameter int          ADDR_W       = 8,
    parameter logic [31:0] CONFIG_RESET = 32'h0000_0000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    input  logic [3:0]        req_wstrb_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o,
    output logic [31:0]       sys_config_o,
    input  logic [31:0]       sys_status_i,
    output logic              irq_o
);
    localparam logic IDLE = 1'b0;
    localparam logic RESP = 1'b1;

    logic        state;
    logic [31:0] config_q;
    logic [3:0]  prev_q, sticky_q, mask_q, rise, w1c;
    logic [11:0] ipc_q, ipc_base, sample;
    logic        accept, wen, err;
    logic        sel_cfg, sel_sta, sel_stk, sel_ipc, sel_msk, sel_clr;
    logic [31:0] rd_data;

    assign accept  = req_valid_i && state == IDLE;
    assign sel_cfg = req_addr_i == ADDR_W'('h00);
    assign sel_sta = req_addr_i == ADDR_W'('h04);
    assign sel_stk = req_addr_i == ADDR_W'('h08);
    assign sel_ipc = req_addr_i == ADDR_W'('h0C);
    assign sel_clr = req_addr_i == ADDR_W'('h14);

    always_comb begin
        err = req_write_i ? !(sel_cfg || sel_stk || sel_msk || sel_clr)
                          : !(sel_cfg || sel_sta || sel_stk || sel_ipc || sel_msk);
        rd_data = (err || req_write_i) ? 32'h0 :
                  sel_cfg ? config_q :
                  sel_sta ? sys_status_i :
                  sel_stk ? {28'h0, sticky_q} :
                  sel_ipc ? {20'h0, ipc_q} :
                  sel_msk ? {28'h0, mask_q} : 32'h0;
        wen      = accept && req_write_i && !err;
        rise     = sys_status_i[7:4] & ~prev_q;
        w1c      = (wen && sel_stk && req_wstrb_i[0]) ? req_wdata_i[3:0] : 4'h0;
        sample   = sys_status_i[27:16];
        // clear-then-compare: a sample arriving with CLEAR becomes the new peak
        ipc_base = (wen && sel_clr && req_wstrb_i[0] && req_wdata_i[0]) ? 12'h0 : ipc_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            rsp_rdata_o <= 32'h0;
            rsp_err_o   <= 1'b0;
            config_q    <= CONFIG_RESET;
            prev_q      <= 4'h0;
            sticky_q    <= 4'h0;
            ipc_q       <= 12'h0;
        end else begin
            prev_q   <= sys_status_i[7:4];
            sticky_q <= (sticky_q & ~w1c) | rise;
            ipc_q    <= sample > ipc_base ? sample : ipc_base;
            for (int i = 0; i < 4; i++)
                if (wen && sel_cfg && req_wstrb_i[i]) config_q[8*i +: 8] <= req_wdata_i[8*i +: 8];
            if (accept) begin
                state       <= RESP;
                rsp_rdata_o <= rd_data;
                rsp_err_o   <= err;
            end else if (state == RESP && rsp_ready_i) begin
                state <= IDLE;
            end
        end
    end

`ifdef SYS_CSR_IRQ_EN
    logic irq_q;
    assign sel_msk = req_addr_i == ADDR_W'('h10);
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mask_q <= 4'h0;
            irq_q  <= 1'b0;
        end else begin
            if (wen && sel_msk && req_wstrb_i[0]) mask_q <= req_wdata_i[3:0];
            irq_q <= |(sticky_q & mask_q);
        end
    end
    assign irq_o = irq_q;
`else
    assign sel_msk = 1'b0;
    assign mask_q  = 4'h0;
    assign irq_o   = 1'b0;
`endif

    assign req_ready_o  = state == IDLE;
    assign rsp_valid_o  = state == RESP;
    assign sys_config_o = config_q;
endmodule

// File: tb/tb_sys_csr_bridge.sv
// tb_sys_csr_bridge: directed self-checking bench for sys_csr_bridge (default build or SYS_CSR_IRQ_EN).
module tb_sys_csr_bridge;
    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [7:0]  req_addr = 8'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [3:0]  req_wstrb = 4'h0;
    logic        rsp_valid, rsp_ready = 1'b1, rsp_err, irq;
    logic [31:0] rsp_rdata, sys_config, status = 32'h0;
    logic [31:0] rd, hold;
    logic        er;
    int          errors = 0, checks = 0;

    sys_csr_bridge dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err), .sys_config_o(sys_config), .sys_status_i(status), .irq_o(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    task automatic access(input logic w, input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rdata, output logic err);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s; rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rdata = rsp_rdata; err = rsp_err;
        if (!rsp_valid) begin err = 1'bx; rdata = 32'hx; end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if ({rsp_err, rsp_rdata} !== 33'h0) begin errors++; $display("FAIL reset_rsp got=%b/%h exp=0/0", rsp_err, rsp_rdata); end
        checks++; if (sys_config !== 32'h0) begin errors++; $display("FAIL reset_config got=%h exp=0", sys_config); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
        rst = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h00;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL pre_accept_valid got=%b exp=0", rsp_valid); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL latency_valid got=%b exp=1", rsp_valid); end
        checks++; if ({rsp_err, rsp_rdata} !== 33'h0) begin errors++; $display("FAIL read_cfg_reset got=%b/%h exp=0/00000000", rsp_err, rsp_rdata); end
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL handshake_done valid=%b ready=%b exp=0/1", rsp_valid, req_ready); end
    endtask

    task automatic test_config;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h00; req_wdata = 32'hAABB_CCDD; req_wstrb = 4'b0101;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++; if (sys_config !== 32'h00BB_00DD) begin errors++; $display("FAIL cfg_strobe got=%h exp=00bb00dd", sys_config); end
        checks++; if ({rsp_err, rsp_rdata} !== 33'h0) begin errors++; $display("FAIL cfg_write_rsp got=%b/%h exp=0/0", rsp_err, rsp_rdata); end
        @(posedge clk); #1;
        access(1'b0, 8'h00, 32'h0, 4'h0, rd, er);
        checks++; if ({er, rd} !== {1'b0, 32'h00BB_00DD}) begin errors++; $display("FAIL cfg_readback got=%b/%h exp=0/00bb00dd", er, rd); end
        access(1'b1, 8'h00, 32'hFFFF_FFFF, 4'h0, rd, er);
        checks++; if (er !== 1'b0 || sys_config !== 32'h00BB_00DD) begin errors++; $display("FAIL cfg_wstrb0 err=%b cfg=%h exp=0/00bb00dd", er, sys_config); end
        access(1'b1, 8'h00, 32'h1122_3344, 4'b1010, rd, er);
        access(1'b0, 8'h00, 32'h0, 4'h0, rd, er);
        checks++; if ({er, rd} !== {1'b0, 32'h11BB_33DD}) begin errors++; $display("FAIL cfg_merge got=%b/%h exp=0/11bb33dd", er, rd); end
    endtask

    task automatic test_sticky;
        @(negedge clk); status[7] = 1'b1;
        access(1'b0, 8'h08, 32'h0, 4'h0, rd, er);
        checks++; if ({er, rd} !== {1'b0, 32'h8}) begin errors++; $display("FAIL sticky_rise got=%b/%h exp=0/00000008", er, rd); end
        @(negedge clk); status[7] = 1'b0;
        @(negedge clk);
        status[7] = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h08; req_wdata = 32'h8; req_wstrb = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL sticky_w1c_err got=%b exp=0", rsp_err); end
        @(posedge clk); #1;
        access(1'b0, 8'h08, 32'h0, 4'h0, rd, er);
        checks++; if (rd !== 32'h8) begin errors++; $display("FAIL sticky_set_wins got=%h exp=00000008", rd); end
        access(1'b1, 8'h08, 32'h8, 4'hF, rd, er);
        access(1'b0, 8'h08, 32'h0, 4'h0, rd, er);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL sticky_cleared got=%h exp=00000000", rd); end
    endtask

    task automatic test_ipc;
        @(negedge clk); status[27:16] = 12'h030;
        @(negedge clk); status[27:16] = 12'h120;
        @(negedge clk); status[27:16] = 12'h050;
        access(1'b0, 8'h0C, 32'h0, 4'h0, rd, er);
        checks++; if ({er, rd} !== {1'b0, 32'h120}) begin errors++; $display("FAIL ipc_max got=%b/%h exp=0/00000120", er, rd); end
        access(1'b0, 8'h04, 32'h0, 4'h0, rd, er);
        checks++; if ({er, rd} !== {1'b0, 32'h0050_0080}) begin errors++; $display("FAIL status_snap got=%b/%h exp=0/00500080", er, rd); end
        access(1'b1, 8'h14, 32'h1, 4'hF, rd, er);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL clear_err got=%b exp=0", er); end
        access(1'b0, 8'h0C, 32'h0, 4'h0, rd, er);
        checks++; if (rd !== 32'h050) begin errors++; $display("FAIL ipc_after_clear got=%h exp=00000050", rd); end
    endtask

    task automatic test_errors;
        access(1'b0, 8'h02, 32'h0, 4'h0, rd, er);
        checks++; if ({er, rd} !== {1'b1, 32'h0}) begin errors++; $display("FAIL misaligned got=%b/%h exp=1/0", er, rd); end
        access(1'b1, 8'h04, 32'hFFFF_FFFF, 4'hF, rd, er);
        checks++; if ({er, rd} !== {1'b1, 32'h0}) begin errors++; $display("FAIL write_status got=%b/%h exp=1/0", er, rd); end
        checks++; if (sys_config !== 32'h11BB_33DD) begin errors++; $display("FAIL cfg_untouched got=%h exp=11bb33dd", sys_config); end
        access(1'b1, 8'h0C, 32'h0, 4'hF, rd, er);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL write_ipc got=%b exp=1", er); end
        access(1'b0, 8'h14, 32'h0, 4'h0, rd, er);
        checks++; if ({er, rd} !== {1'b1, 32'h0}) begin errors++; $display("FAIL read_clear got=%b/%h exp=1/0", er, rd); end
        access(1'b0, 8'h18, 32'h0, 4'h0, rd, er);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL unmapped got=%b exp=1", er); end
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h00; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0; hold = rsp_rdata;
        checks++; if (hold !== 32'h11BB_33DD) begin errors++; $display("FAIL stall_data got=%h exp=11bb33dd", hold); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== hold || rsp_err !== 1'b0) begin
                errors++; $display("FAIL stall_hold cyc=%0d valid=%b ready=%b data=%h err=%b exp=1/0/%h/0", i, rsp_valid, req_ready, rsp_rdata, rsp_err, hold);
            end
        end
        @(negedge clk); rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL stall_release valid=%b ready=%b exp=0/1", rsp_valid, req_ready); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h00; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL mid_accept got=%b exp=1", rsp_valid); end
        rst = 1'b1; #1;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || sys_config !== 32'h0) begin errors++; $display("FAIL mid_reset valid=%b ready=%b cfg=%h exp=0/1/0", rsp_valid, req_ready, sys_config); end
        @(negedge clk); rst = 1'b0; rsp_ready = 1'b1;
        repeat (2) @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_no_rsp got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_irq;
`ifdef SYS_CSR_IRQ_EN
        access(1'b1, 8'h10, 32'h1, 4'hF, rd, er);
        access(1'b0, 8'h10, 32'h0, 4'h0, rd, er);
        checks++; if ({er, rd} !== {1'b0, 32'h1}) begin errors++; $display("FAIL mask_read got=%b/%h exp=0/00000001", er, rd); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_masked got=%b exp=0", irq); end
        @(negedge clk); status[4] = 1'b1;
        @(posedge clk); #1;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_early got=%b exp=0", irq); end
        @(posedge clk); #1;
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_assert got=%b exp=1", irq); end
        access(1'b1, 8'h08, 32'h1, 4'hF, rd, er);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got=%b exp=0", irq); end
`else
        @(negedge clk); status[4] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_tied cyc=%0d got=%b exp=0", i, irq); end
        end
        access(1'b0, 8'h10, 32'h0, 4'h0, rd, er);
        checks++; if ({er, rd} !== {1'b1, 32'h0}) begin errors++; $display("FAIL mask_unmapped got=%b/%h exp=1/0", er, rd); end
`endif
    endtask

    initial begin
        test_reset;
        test_config;
        test_sticky;
        test_ipc;
        test_errors;
        test_reset_mid;
        test_irq;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
